// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel that feeds the instruction-memory boot loader.
interface imem_boot_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses SYNC/LEN/payload/CSUM frames into 16-bit imem writes and releases the core on success.
// Optional inter-byte timeout enabled by defining BOOT_TIMEOUT_EN.
module imem_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned ADDR_W         = 8
`ifdef BOOT_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    input  logic                reload,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [15:0]         imem_wdata,
    output logic                cpu_reset,
    output logic                done,
    output logic                error
);

    localparam int unsigned LEN_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN, ST_HI, ST_LO, ST_CSUM, ST_DONE, ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          hi_q, hi_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [15:0]         imem_wdata_q, imem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                rx_ready_c;
    logic                accept_c;

`ifdef BOOT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign rx_ready_c   = (state_q != ST_DONE);
    assign accept_c     = bus.rx_valid && rx_ready_c;
    assign bus.rx_ready = rx_ready_c;

    // Frame parser; outputs are computed here and registered below.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        words_d      = words_q;
        count_d      = count_q;
        csum_d       = csum_q;
        hi_d         = hi_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;
        error_d      = error_q;
`ifdef BOOT_TIMEOUT_EN
        tmo_d        = '0;
`endif

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (accept_c && bus.rx_data == SYNC_BYTE) begin
                    csum_d  = 8'h00;
                    count_d = '0;
                    words_d = '0;
                    error_d = 1'b0;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept_c) begin
                    // A length byte of zero encodes a full 256-word image.
                    len_d   = (bus.rx_data == 8'h00) ? LEN_W'(256) : LEN_W'(bus.rx_data);
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (accept_c) begin
                    hi_d    = bus.rx_data;
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (accept_c) begin
                    csum_d       = csum_q ^ bus.rx_data;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = count_q;
                    imem_wdata_d = {hi_q, bus.rx_data};
                    count_d      = count_q + ADDR_W'(1);
                    words_d      = words_q + LEN_W'(1);
                    state_d      = (words_q + LEN_W'(1) == len_q) ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    if (bus.rx_data == csum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (reload) begin
                    state_d     = ST_IDLE;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BOOT_TIMEOUT_EN
        // Inter-byte watchdog while a frame is in flight.
        if ((state_q == ST_LEN || state_q == ST_HI || state_q == ST_LO || state_q == ST_CSUM)
            && !accept_c) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_ERR;
                error_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            words_q      <= '0;
            count_q      <= '0;
            csum_q       <= 8'h00;
            hi_q         <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 16'h0000;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            words_q      <= words_d;
            count_q      <= count_d;
            csum_q       <= csum_d;
            hi_q         <= hi_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef BOOT_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes queued as LO bytes are sent, popped on imem_we.
module tb_imem_boot_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_boot_loader_if bus ();

    int   n_cmp;
    int   n_err;
    wr_t  sb[$];
    logic prev_we;
    logic [15:0] img [256];

`ifdef BOOT_TIMEOUT_EN
    imem_boot_loader #(.TIMEOUT_CYCLES(16)) dut (
`else
    imem_boot_loader dut (
`endif
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            check("we_single_cycle", 32'(prev_we), 32'd0);
            if (sb.size() == 0) begin
                check("sb_has_entry_at_write", 32'(sb.size()), 32'd1);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", 32'(imem_wdata), 32'(e.data));
            end
        end
        if (!reset && !done && !cpu_reset)
            check("cpu_reset_glitch", 32'(cpu_reset), 32'd1);
        prev_we = imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("byte_stall", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Sends img[0..nwords-1] as a frame; bad=1 corrupts the checksum byte.
    task automatic send_image(input int nwords, input bit bad);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(8'hA5);
        send_byte(8'(nwords));
        for (int i = 0; i < nwords; i++) begin
            cs = cs ^ img[i][15:8] ^ img[i][7:0];
            send_byte(img[i][15:8]);
            push_wr(8'(i), img[i]);
            send_byte(img[i][7:0]);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs);
    endtask

    task automatic send_good_explicit();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h48);
        push_wr(8'h00, 16'h4810);
        send_byte(8'h10);
        send_byte(8'h12);
        push_wr(8'h01, 16'h1200);
        send_byte(8'h00);
        send_byte(8'h4A);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic expect_status(input string tag, input logic d, input logic e, input logic cr);
        check({tag, "_done"},      32'(done),      32'(d));
        check({tag, "_error"},     32'(error),     32'(e));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        check({tag, "_sb_drain"},  32'(sb.size()), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        prev_we = 1'b0;
        reset = 1'b1;
        reload = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_imem_we",    32'(imem_we),      32'd0);
        check("rst_imem_addr",  32'(imem_addr),    32'd0);
        check("rst_imem_wdata", 32'(imem_wdata),   32'd0);
        check("rst_rx_ready",   32'(bus.rx_ready), 32'd1);
        expect_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // Good frame, then DONE/reload handshake.
        send_good_explicit();
        expect_status("good", 1'b1, 1'b0, 1'b0);
        check("good_rx_ready", 32'(bus.rx_ready), 32'd0);
        pulse_reload();
        check("reload_cpu_reset", 32'(cpu_reset),    32'd1);
        check("reload_done",      32'(done),         32'd0);
        check("reload_rx_ready",  32'(bus.rx_ready), 32'd1);

        // Bad checksum, reload ignored outside DONE, then recovery.
        img[0] = 16'h4810;
        img[1] = 16'h1200;
        send_image(2, 1'b1);
        expect_status("badcs", 1'b0, 1'b1, 1'b1);
        pulse_reload();
        check("reload_in_err_error", 32'(error), 32'd1);
        for (int i = 0; i < 5; i++) img[i] = 16'(32'h3C00 + 32'(i) * 32'h0111);
        send_image(5, 1'b0);
        expect_status("recover", 1'b1, 1'b0, 1'b0);
        pulse_reload();

        // Leading garbage must be dropped without any write.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_good_explicit();
        expect_status("garbage", 1'b1, 1'b0, 1'b0);
        pulse_reload();

        // Full 256-word image with SYNC-valued payload bytes.
        for (int i = 0; i < 256; i++) img[i] = 16'($urandom);
        img[3]   = 16'hA5A5;
        img[255] = 16'h00A5;
        send_image(256, 1'b0);
        check("full_last_addr", 32'(imem_addr), 32'hFF);
        expect_status("full", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset out of DONE takes effect before the next clock edge.
        #2 reset = 1'b1;
        #1;
        check("async_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("async_rst_done",      32'(done),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-frame after the third payload byte; leftover bytes land in IDLE.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h48);
        push_wr(8'h00, 16'h4810);
        send_byte(8'h10);
        send_byte(8'h12);
        #2 reset = 1'b1;
        #1;
        check("midrst_imem_we",  32'(imem_we),      32'd0);
        check("midrst_rx_ready", 32'(bus.rx_ready), 32'd1);
        expect_status("midrst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h4A);
        check("midrst_no_done", 32'(done), 32'd0);
        send_good_explicit();
        expect_status("after_midrst", 1'b1, 1'b0, 1'b0);
        pulse_reload();

        // Stall after the first payload byte.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h48);
        repeat (40) @(negedge clk);
`ifdef BOOT_TIMEOUT_EN
        expect_status("timeout", 1'b0, 1'b1, 1'b1);
        img[0] = 16'h4810;
        img[1] = 16'h1200;
        send_image(2, 1'b0);
        expect_status("after_timeout", 1'b1, 1'b0, 1'b0);
`else
        check("stall_error", 32'(error), 32'd0);
        push_wr(8'h00, 16'h4810);
        send_byte(8'h10);
        send_byte(8'h12);
        push_wr(8'h01, 16'h1200);
        send_byte(8'h00);
        send_byte(8'h4A);
        expect_status("stall_resume", 1'b1, 1'b0, 1'b0);
`endif
        pulse_reload();
        check("final_rx_ready", 32'(bus.rx_ready), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
